// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// memory_stage : load/store pipeline stage with a start/ready/valid data-memory
//                handshake, byte-lane alignment, load extension and upstream stall.
// Revision    : 1.0
// ============================================================================
module memory_stage #(
    parameter int         ADDR_W   = 32,
    parameter logic [1:0] OP_NONE  = 2'd0,
    parameter logic [1:0] OP_LOAD  = 2'd1,
    parameter logic [1:0] OP_STORE = 2'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_branch_hazard,
    input  logic [31:0]       input_reg_pc,
    input  logic [31:0]       input_alu_out,
    input  logic [31:0]       input_rs2_data,
    input  logic [1:0]        input_mem_op,
    input  logic [2:0]        input_mem_funct,
    input  logic              input_rf_wen,
    input  logic [4:0]        input_wb_addr,
    output logic              mem_cmd_start,
    output logic              mem_cmd_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_cmd_ready,
    input  logic              mem_rdata_valid,
    input  logic [31:0]       mem_rdata,
    output logic              stall_flg,
    output logic [31:0]       output_reg_pc,
    output logic              output_rf_wen,
    output logic [4:0]        output_wb_addr,
    output logic [31:0]       output_wb_data,
    output logic              output_misaligned
);
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_READY = 2'd1;
    localparam logic [1:0] S_WAIT_VALID = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] cap_pc;
    logic [31:0] cap_addr;
    logic [31:0] cap_rs2;
    logic [2:0]  cap_funct;
    logic        cap_rf_wen;
    logic [4:0]  cap_wb_addr;
    logic        cap_store;
    logic        kill;

    logic        in_idle;
    logic        live_mem_op;
    logic        misaligned;
    logic        issue;
    logic [31:0] sel_addr;
    logic [31:0] sel_rs2;
    logic [2:0]  sel_funct;
    logic        sel_store;
    logic [1:0]  lane;
    logic        is_byte;
    logic        is_half;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // In IDLE the memory port is driven from the live inputs, otherwise from the captured copy.
    assign in_idle   = (state == S_IDLE);
    assign sel_addr  = in_idle ? input_alu_out   : cap_addr;
    assign sel_rs2   = in_idle ? input_rs2_data  : cap_rs2;
    assign sel_funct = in_idle ? input_mem_funct : cap_funct;
    assign sel_store = in_idle ? (input_mem_op == OP_STORE) : cap_store;

    assign lane        = sel_addr[1:0];
    assign is_byte     = (sel_funct[1:0] == 2'b00);
    assign is_half     = (sel_funct[1:0] == 2'b01);
    assign live_mem_op = (input_mem_op == OP_LOAD) || (input_mem_op == OP_STORE);
    assign misaligned  = (is_half && sel_addr[0]) ||
                         (!is_byte && !is_half && (sel_addr[1:0] != 2'b00));
    assign issue       = in_idle && live_mem_op && !wb_branch_hazard && !misaligned;

    assign mem_addr      = {sel_addr[ADDR_W-1:2], 2'b00};
    assign mem_cmd_write = sel_store;

    always_comb begin
        mem_wdata = sel_rs2;
        mem_wmask = 4'b1111;
        if (is_byte) begin
            mem_wdata = {4{sel_rs2[7:0]}};
            mem_wmask = 4'b0001 << lane;
        end else if (is_half) begin
            mem_wdata = {2{sel_rs2[15:0]}};
            mem_wmask = 4'b0011 << lane;
        end
    end

    assign ld_byte = mem_rdata[{lane, 3'b000} +: 8];
    assign ld_half = mem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = mem_rdata;
        if (is_byte) begin
            ld_data = sel_funct[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            ld_data = sel_funct[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    if (!mem_cmd_ready) begin
                        state_nxt = S_WAIT_READY;
                    end else if (input_mem_op == OP_LOAD) begin
                        state_nxt = S_WAIT_VALID;
                    end
                end
            end
            S_WAIT_READY: begin
                if (mem_cmd_ready) begin
                    state_nxt = cap_store ? S_IDLE : S_WAIT_VALID;
                end
            end
            S_WAIT_VALID: begin
                if (mem_rdata_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gated by rst so the request and stall vanish the moment reset asserts.
    always_comb begin
        mem_cmd_start = 1'b0;
        stall_flg     = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    mem_cmd_start = issue;
                    stall_flg     = issue && !(sel_store && mem_cmd_ready);
                end
                S_WAIT_READY: begin
                    mem_cmd_start = 1'b1;
                    stall_flg     = !(cap_store && mem_cmd_ready);
                end
                S_WAIT_VALID: begin
                    stall_flg = !mem_rdata_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_pc            <= 32'd0;
            cap_addr          <= 32'd0;
            cap_rs2           <= 32'd0;
            cap_funct         <= 3'd0;
            cap_rf_wen        <= 1'b0;
            cap_wb_addr       <= 5'd0;
            cap_store         <= 1'b0;
            kill              <= 1'b0;
            output_reg_pc     <= 32'd0;
            output_rf_wen     <= 1'b0;
            output_wb_addr    <= 5'd0;
            output_wb_data    <= 32'd0;
            output_misaligned <= 1'b0;
        end else begin
            output_rf_wen     <= 1'b0;
            output_misaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        cap_pc      <= input_reg_pc;
                        cap_addr    <= input_alu_out;
                        cap_rs2     <= input_rs2_data;
                        cap_funct   <= input_mem_funct;
                        cap_rf_wen  <= input_rf_wen;
                        cap_wb_addr <= input_wb_addr;
                        cap_store   <= (input_mem_op == OP_STORE);
                        kill        <= wb_branch_hazard;
                    end
                    output_reg_pc     <= input_reg_pc;
                    output_wb_addr    <= input_wb_addr;
                    output_wb_data    <= input_alu_out;
                    output_rf_wen     <= input_rf_wen && !wb_branch_hazard && !live_mem_op;
                    output_misaligned <= live_mem_op && !wb_branch_hazard && misaligned;
                end
                S_WAIT_READY: begin
                    kill <= kill | wb_branch_hazard;
                    if (mem_cmd_ready && cap_store) begin
                        output_reg_pc  <= cap_pc;
                        output_wb_addr <= cap_wb_addr;
                    end
                end
                S_WAIT_VALID: begin
                    kill <= kill | wb_branch_hazard;
                    if (mem_rdata_valid) begin
                        output_reg_pc  <= cap_pc;
                        output_wb_addr <= cap_wb_addr;
                        output_wb_data <= ld_data;
                        output_rf_wen  <= cap_rf_wen && !kill && !wb_branch_hazard;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// tb_memory_stage : directed table, hand sequences and randomized ops checked
//                   against an arithmetic reference model of the memory stage.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_branch_hazard;
    logic [31:0] input_reg_pc;
    logic [31:0] input_alu_out;
    logic [31:0] input_rs2_data;
    logic [1:0]  input_mem_op;
    logic [2:0]  input_mem_funct;
    logic        input_rf_wen;
    logic [4:0]  input_wb_addr;
    logic        mem_cmd_start;
    logic        mem_cmd_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_cmd_ready;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        stall_flg;
    logic [31:0] output_reg_pc;
    logic        output_rf_wen;
    logic [4:0]  output_wb_addr;
    logic [31:0] output_wb_data;
    logic        output_misaligned;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst), .wb_branch_hazard(wb_branch_hazard),
        .input_reg_pc(input_reg_pc), .input_alu_out(input_alu_out),
        .input_rs2_data(input_rs2_data), .input_mem_op(input_mem_op),
        .input_mem_funct(input_mem_funct), .input_rf_wen(input_rf_wen),
        .input_wb_addr(input_wb_addr), .mem_cmd_start(mem_cmd_start),
        .mem_cmd_write(mem_cmd_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_cmd_ready(mem_cmd_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .stall_flg(stall_flg), .output_reg_pc(output_reg_pc),
        .output_rf_wen(output_rf_wen), .output_wb_addr(output_wb_addr),
        .output_wb_data(output_wb_data), .output_misaligned(output_misaligned)
    );

    // hz_mode: 0 none, 1 hazard on the issue cycle, 2 hazard one cycle into the stall
    typedef struct {
        logic [31:0] pc, alu, rs2, rdata;
        logic [1:0]  op;
        logic [2:0]  funct;
        logic        rfwen;
        logic [4:0]  wbaddr;
        int          hz_mode, rdy_dly, val_dly;
        logic        exp_req, exp_rf_wen, exp_mis, chk_data;
        logic [31:0] exp_wdata, exp_wb_data;
        logic [3:0]  exp_wmask;
        int          exp_stalls;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    string cur_tag  = "init";
    vec_t  tab[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %h expected %h", cur_tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, alu, rs2, input logic [1:0] op,
                                input logic [2:0] funct, input logic rfwen, input logic [4:0] wbaddr,
                                input int hz, rdy, val, input logic [31:0] rdata,
                                input logic req, input logic [31:0] wdata, input logic [3:0] wmask,
                                input int stalls, input logic rf, mis, chkd, input logic [31:0] wbd);
        vec_t v;
        v.pc = pc; v.alu = alu; v.rs2 = rs2; v.op = op; v.funct = funct; v.rfwen = rfwen;
        v.wbaddr = wbaddr; v.hz_mode = hz; v.rdy_dly = rdy; v.val_dly = val; v.rdata = rdata;
        v.exp_req = req; v.exp_wdata = wdata; v.exp_wmask = wmask; v.exp_stalls = stalls;
        v.exp_rf_wen = rf; v.exp_mis = mis; v.chk_data = chkd; v.exp_wb_data = wbd;
        return v;
    endfunction

    // Reference model: access size and lane from the address, plain arithmetic for data.
    function automatic vec_t model(input vec_t v);
        vec_t            r;
        int unsigned     sz;
        int unsigned     lane;
        longint unsigned val;
        longint unsigned lim;
        r = v;
        lane = v.alu % 4;
        sz = (v.funct % 4 == 0) ? 1 : ((v.funct % 4 == 1) ? 2 : 4);
        r.exp_req = 0; r.exp_mis = 0; r.exp_rf_wen = 0; r.chk_data = 0;
        r.exp_wdata = 0; r.exp_wmask = 0; r.exp_stalls = 0; r.exp_wb_data = 0;
        if (v.op == 2'd0 || v.hz_mode == 1) begin
            r.exp_rf_wen  = v.rfwen && (v.hz_mode != 1);
            r.chk_data    = 1;
            r.exp_wb_data = v.alu;
        end else if (v.alu % sz != 0) begin
            r.exp_mis = 1;
        end else if (v.op == 2'd2) begin
            r.exp_req    = 1;
            r.exp_stalls = v.rdy_dly;
            if (sz == 1)      r.exp_wdata = (v.rs2 % 256) * 32'h0101_0101;
            else if (sz == 2) r.exp_wdata = (v.rs2 % 65536) * 32'h0001_0001;
            else              r.exp_wdata = v.rs2;
            r.exp_wmask = 4'(((1 << sz) - 1) << lane);
        end else begin
            r.exp_req    = 1;
            r.exp_stalls = v.rdy_dly + 1 + v.val_dly;
            lim = 64'd1 << (8 * sz);
            val = (64'(v.rdata) >> (8 * lane)) % lim;
            if (v.funct < 4 && sz < 4 && val >= lim / 2) val = val - lim;
            r.exp_wb_data = 32'(val);
            r.exp_rf_wen  = v.rfwen && (v.hz_mode != 2);
            r.chk_data    = 1;
        end
        return r;
    endfunction

    // Entered just after a rising edge with the stage idle; leaves in the same phase.
    task automatic run_vec(input vec_t v);
        int c = 0;
        int acc = 0;
        bit acc_f = 0;
        bit done = 0;
        int stalls = 0;
        input_reg_pc = v.pc; input_alu_out = v.alu; input_rs2_data = v.rs2;
        input_mem_op = v.op; input_mem_funct = v.funct; input_rf_wen = v.rfwen;
        input_wb_addr = v.wbaddr;
        while (!done && c < 64) begin
            if (c > 0) begin
                input_reg_pc = $urandom; input_alu_out = $urandom; input_rs2_data = $urandom;
                input_mem_funct = 3'($urandom); input_rf_wen = 1'($urandom);
                input_wb_addr = 5'($urandom);
            end
            mem_cmd_ready    = !acc_f && (c >= v.rdy_dly);
            mem_rdata_valid  = acc_f && (v.op == 2'd1) && (c == acc + 1 + v.val_dly);
            mem_rdata        = mem_rdata_valid ? v.rdata : $urandom;
            wb_branch_hazard = (v.hz_mode == 1 && c == 0) || (v.hz_mode == 2 && c == 1);
            @(negedge clk);
            if (c == 0) chk("start", mem_cmd_start, v.exp_req);
            else        chk("bubble_rf_wen", output_rf_wen, 1'b0);
            if (mem_cmd_start && v.exp_req) begin
                chk("mem_addr", mem_addr, v.alu & 32'hFFFF_FFFC);
                chk("mem_write", mem_cmd_write, v.op == 2'd2);
                if (v.op == 2'd2) begin
                    chk("mem_wdata", mem_wdata, v.exp_wdata);
                    chk("mem_wmask", mem_wmask, v.exp_wmask);
                end
            end
            if (mem_cmd_start && mem_cmd_ready) begin
                acc_f = 1;
                acc   = c;
            end
            if (stall_flg) stalls++;
            else           done = 1;
            @(posedge clk);
            #1;
            c++;
        end
        mem_cmd_ready = 0; mem_rdata_valid = 0; wb_branch_hazard = 0;
        if (!done) begin
            failures++;
            $display("FAIL %s.timeout: stall_flg still %b after %0d cycles, required 0", cur_tag, stall_flg, c);
            return;
        end
        chk("stall_cycles", stalls, v.exp_stalls);
        chk("rf_wen", output_rf_wen, v.exp_rf_wen);
        chk("misaligned", output_misaligned, v.exp_mis);
        if (v.chk_data) chk("wb_data", output_wb_data, v.exp_wb_data);
        if (!v.exp_mis) begin
            chk("pc", output_reg_pc, v.pc);
            chk("wb_addr", output_wb_addr, v.wbaddr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1; wb_branch_hazard = 0; input_reg_pc = 0; input_alu_out = 0; input_rs2_data = 0;
        input_mem_op = 0; input_mem_funct = 0; input_rf_wen = 0; input_wb_addr = 0;
        mem_cmd_ready = 0; mem_rdata_valid = 0; mem_rdata = 0;

        //        pc         alu         rs2          op funct   rf wb hz rd vd rdata         req wdata         wmask    st rf mis chk wb_data
        tab[0]  = mk(32'h1000, 32'h1234, 32'h0,        0, 3'b000, 1, 5, 0, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 0, 1, 0, 1, 32'h1234);
        tab[1]  = mk(32'h1004, 32'h0103, 32'hAB,       2, 3'b000, 1, 4, 0, 0, 0, 32'h0,        1, 32'hABABABAB, 4'b1000, 0, 0, 0, 0, 32'h0);
        tab[2]  = mk(32'h1008, 32'h0101, 32'h0,        1, 3'b000, 1, 7, 0, 2, 2, 32'h000080FF, 1, 32'h0,        4'b0000, 5, 1, 0, 1, 32'hFFFFFF80);
        tab[3]  = mk(32'h100C, 32'h0202, 32'h0,        1, 3'b101, 1, 8, 0, 0, 0, 32'hBEEF1234, 1, 32'h0,        4'b0000, 1, 1, 0, 1, 32'h0000BEEF);
        tab[4]  = mk(32'h1010, 32'h0202, 32'h0,        1, 3'b001, 1, 9, 0, 0, 0, 32'hBEEF1234, 1, 32'h0,        4'b0000, 1, 1, 0, 1, 32'hFFFFBEEF);
        tab[5]  = mk(32'h1014, 32'h0102, 32'h0,        1, 3'b010, 1,10, 0, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 0, 0, 1, 0, 32'h0);
        tab[6]  = mk(32'h1018, 32'h0100, 32'h0,        1, 3'b010, 1,11, 2, 0, 2, 32'h11223344, 1, 32'h0,        4'b0000, 3, 0, 0, 0, 32'h0);
        tab[7]  = mk(32'h101C, 32'h0106, 32'h1234ABCD, 2, 3'b001, 1, 2, 0, 1, 0, 32'h0,        1, 32'hABCDABCD, 4'b1100, 1, 0, 0, 0, 32'h0);
        tab[8]  = mk(32'h1020, 32'h0020, 32'hDEADBEEF, 2, 3'b010, 0, 1, 0, 0, 0, 32'h0,        1, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0, 32'h0);
        tab[9]  = mk(32'h1024, 32'h0203, 32'h0,        1, 3'b100, 1,12, 0, 1, 1, 32'h80000000, 1, 32'h0,        4'b0000, 3, 1, 0, 1, 32'h00000080);
        tab[10] = mk(32'h1028, 32'h0203, 32'h0,        1, 3'b000, 1,13, 0, 0, 3, 32'h80000000, 1, 32'h0,        4'b0000, 4, 1, 0, 1, 32'hFFFFFF80);
        tab[11] = mk(32'h102C, 32'h0300, 32'h0,        1, 3'b010, 1,14, 1, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 0, 0, 0, 1, 32'h0300);
        tab[12] = mk(32'h1030, 32'h0101, 32'h5555,     2, 3'b001, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 0, 0, 1, 0, 32'h0);
        tab[13] = mk(32'h1034, 32'h0104, 32'h0,        1, 3'b011, 1,15, 0, 0, 1, 32'hCAFEF00D, 1, 32'h0,        4'b0000, 2, 1, 0, 1, 32'hCAFEF00D);
        tab[14] = mk(32'h1038, 32'h5555AAAA, 32'h0,    0, 3'b000, 0, 3, 0, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 0, 0, 0, 1, 32'h5555AAAA);
        tab[15] = mk(32'h103C, 32'h0102, 32'h77,       2, 3'b000, 1, 6, 2, 2, 0, 32'h0,        1, 32'h77777777, 4'b0100, 2, 0, 0, 0, 32'h0);
        tab[16] = mk(32'h1040, 32'h0203, 32'h0,        1, 3'b101, 1,16, 0, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 0, 0, 1, 0, 32'h0);

        #12;
        cur_tag = "reset";
        chk("start", mem_cmd_start, 1'b0);
        chk("stall", stall_flg, 1'b0);
        chk("rf_wen", output_rf_wen, 1'b0);
        chk("wb_data", output_wb_data, 32'h0);
        chk("pc", output_reg_pc, 32'h0);
        chk("misaligned", output_misaligned, 1'b0);
        @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 17; i++) begin
            cur_tag = $sformatf("tab%0d", i);
            run_vec(tab[i]);
            if (tab[i].exp_mis) begin
                input_mem_op = 2'd0; input_rf_wen = 1'b0;
                @(posedge clk);
                #1;
                chk("misaligned_drop", output_misaligned, 1'b0);
            end
        end

        // Reset asserted while a load waits for data.
        cur_tag = "reset_mid";
        input_reg_pc = 32'h2000; input_alu_out = 32'h40; input_mem_op = 2'd1;
        input_mem_funct = 3'b010; input_rf_wen = 1; input_wb_addr = 6; mem_cmd_ready = 1;
        @(negedge clk);
        chk("start", mem_cmd_start, 1'b1);
        @(posedge clk);
        #1 mem_cmd_ready = 0;
        @(negedge clk);
        chk("stall_wait_valid", stall_flg, 1'b1);
        #2 rst = 1;
        #1;
        chk("start_in_rst", mem_cmd_start, 1'b0);
        chk("stall_in_rst", stall_flg, 1'b0);
        chk("wb_data_in_rst", output_wb_data, 32'h0);
        chk("pc_in_rst", output_reg_pc, 32'h0);
        chk("wb_addr_in_rst", output_wb_addr, 5'h0);
        input_mem_op = 2'd0; input_rf_wen = 0;
        @(posedge clk);
        #1 rst = 0;
        cur_tag = "post_reset";
        run_vec(tab[0]);

        for (int i = 0; i < 40; i++) begin
            v.pc = $urandom; v.alu = $urandom; v.rs2 = $urandom; v.rdata = $urandom;
            if ($urandom_range(0, 1) == 0) v.alu[1:0] = 2'b00;
            v.op = 2'($urandom_range(0, 2));
            v.funct = (v.op == 2'd2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            v.rfwen = 1'($urandom_range(0, 1)); v.wbaddr = 5'($urandom);
            v.rdy_dly = $urandom_range(0, 3); v.val_dly = $urandom_range(0, 3);
            v.hz_mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            v = model(v);
            if (v.hz_mode == 0 && v.exp_stalls > 0 && $urandom_range(0, 3) == 0) begin
                v.hz_mode = 2;
                v = model(v);
            end
            cur_tag = $sformatf("rnd%0d", i);
            run_vec(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
